cpu_muldiv: RTL
===============

CPU_MULDIV -- requirements
Module: cpu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width, even, >= 8.
REQ-002 SHALL have parameter IDX_W, default 4: width of the destination register index.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high, with the ports named clk_i and rst_i.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 flush_i  in  1  aborts any operation in flight.
REQ-007 start_i  in  1  request to begin an operation.
REQ-008 op_i  in  3  operation: 000 MUL, 001 DIV, 010 UDIV, 011 MOD, 100 UMOD; 101-111 illegal.
REQ-009 a_i  in  WIDTH  multiplicand or dividend.
REQ-010 b_i  in  WIDTH  multiplier or divisor.
REQ-011 dest_index_i  in  IDX_W  destination register index, carried with the operation.
REQ-012 busy_o  out  1  operation in progress.
REQ-013 valid_o  out  1  one-cycle result strobe.
REQ-014 result_o  out  WIDTH  result.
REQ-015 dest_index_o  out  IDX_W  captured destination register index.
REQ-016 div_by_zero_o  out  1  divisor was zero; qualified by valid_o.
REQ-017 illegal_op_o  out  1  op_i was illegal; qualified by valid_o.

Function
REQ-018 SHALL implement a three-state FSM:
- IDLE: waits for start.
- RUN: iterative, radix-2, exactly one bit per cycle for WIDTH cycles.
- DONE: one cycle, then returns to IDLE.
REQ-019 SHALL accept start_i only in IDLE or DONE with flush_i low, capturing op_i, a_i, b_i and dest_index_i at that edge.
REQ-020 SHALL ignore start_i in RUN, with no effect on the operation in flight.
REQ-021 SHALL drive busy_o high exactly while in RUN, registered.
REQ-022 Latency: for a start accepted at edge T, valid_o SHALL be high for exactly the one cycle following edge T+WIDTH+1; result_o and flags SHALL be stable in that cycle.
REQ-023 SHALL allow a start accepted in the DONE cycle to begin immediately, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-024 MUL SHALL produce the low WIDTH bits of a_i*b_i; the result is identical for signed and unsigned operands.
REQ-025 DIV/MOD SHALL be signed and truncate toward zero; the MOD remainder takes the sign of the dividend.
REQ-026 UDIV/UMOD SHALL be unsigned.
REQ-027 Signed operations SHALL run on magnitudes, with sign correction applied in DONE.
REQ-028 Divisor zero SHALL give:
- DIV/UDIV result all-ones; MOD/UMOD result a_i.
- div_by_zero_o=1.
- Same latency as a normal operation.
REQ-029 Signed overflow (a_i = most-negative value, b_i = -1) SHALL give DIV result a_i, MOD result 0, div_by_zero_o=0.
REQ-030 Illegal op SHALL complete with normal latency, result 0 and illegal_op_o=1.
REQ-031 flush_i high in any state SHALL force IDLE at the next edge with valid_o=0 and no result emitted.
REQ-032 flush_i and start_i high in the same cycle: flush SHALL win and the start is dropped.
REQ-033 div_by_zero_o and illegal_op_o SHALL be 0 whenever valid_o=0.
REQ-034 result_o and dest_index_o SHALL hold their last values when valid_o=0.

Reset
REQ-035 rst_i high SHALL immediately force IDLE and busy_o=0, valid_o=0, div_by_zero_o=0, illegal_op_o=0, result_o=0, dest_index_o=0.
REQ-036 rst_i asserted mid-operation SHALL discard the operation; no valid_o SHALL follow deassertion.
REQ-037 The first start SHALL be accepted at the first rising edge after rst_i deasserts.

Verification (WIDTH=32)
REQ-038 MUL a=7 b=6 dest=3, start at edge T -> busy_o for 32 cycles; valid_o only in the cycle after T+33; result 42; dest_index_o 3.
REQ-039 DIV a=-7 b=2 -> 0xFFFFFFFD; MOD on the same operands -> 0xFFFFFFFF; UDIV a=0xFFFFFFF9 b=2 -> 0x7FFFFFFC.
REQ-040 UDIV a=5 b=0 -> result 0xFFFFFFFF, div_by_zero_o=1; UMOD a=5 b=0 -> result 5, div_by_zero_o=1.
REQ-041 DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; MOD on the same operands -> 0; div_by_zero_o=0.
REQ-042 Flush 10 cycles after start, and separately rst_i 10 cycles after start -> no valid_o within 40 cycles; a new MUL 3*3 then yields 9 at nominal latency.
REQ-043 Second start held high through the DONE cycle -> accepted there; both results appear 34 cycles apart; a start during RUN is ignored.

Source files
------------

// File: rtl/cpu_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_muldiv
// Brief    : Iterative radix-2 multiply / divide unit (MUL, DIV, UDIV, MOD, UMOD)
// Revision : 1.0 - initial release
// ============================================================================
module cpu_muldiv #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [IDX_W-1:0] dest_index_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [IDX_W-1:0] dest_index_o,
    output logic             div_by_zero_o,
    output logic             illegal_op_o
);

    localparam logic [2:0] c_OP_MUL  = 3'd0;
    localparam logic [2:0] c_OP_DIV  = 3'd1;
    localparam logic [2:0] c_OP_UDIV = 3'd2;
    localparam logic [2:0] c_OP_MOD  = 3'd3;
    localparam logic [2:0] c_OP_UMOD = 3'd4;

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic               r_busy;
    logic               r_valid;
    logic [WIDTH-1:0]   r_result;
    logic [IDX_W-1:0]   r_dest_out;
    logic               r_dbz_out;
    logic               r_ill_out;

    // r_x: multiplicand (shifts left) or divisor magnitude
    // r_y: multiplier (shifts right) or dividend shifting into quotient
    // r_z: product accumulator or partial remainder
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_z;
    logic [c_CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0]   r_dest;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_ill;

    logic               w_accept;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_final;

    assign w_accept    = start_i && !flush_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_is_signed = (op_i == c_OP_DIV) || (op_i == c_OP_MOD);
    assign w_is_div    = w_is_signed || (op_i == c_OP_UDIV) || (op_i == c_OP_UMOD);
    assign w_a_neg     = w_is_signed && a_i[WIDTH-1];
    assign w_b_neg     = w_is_signed && b_i[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -a_i : a_i;
    assign w_b_mag     = w_b_neg ? -b_i : b_i;

    assign w_mul_sum = r_z + (r_y[0] ? r_x : '0);
    assign w_shift   = {r_z, r_y[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_x});
    // When w_ge holds the true difference is below r_x, so WIDTH bits suffice
    assign w_diff    = w_shift[WIDTH-1:0] - r_x;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_RUN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_RUN;
            S_RUN: begin
                if (flush_i)               w_state_next = S_IDLE;
                else if (r_cnt == c_LAST)  w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush_i) w_state_next = S_IDLE;
    end

    // Sign correction of the magnitude results happens here, during DONE
    always_comb begin
        w_final = '0;
        case (r_op)
            c_OP_MUL:  w_final = r_z;
            c_OP_DIV:  w_final = r_dz ? '1 : (r_neg_q ? -r_y : r_y);
            c_OP_UDIV: w_final = r_dz ? '1 : r_y;
            c_OP_MOD:  w_final = r_neg_r ? -r_z : r_z;
            c_OP_UMOD: w_final = r_z;
            default:   w_final = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cnt   <= '0;
            r_dest  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_ill   <= 1'b0;
        end else if (w_accept) begin
            r_op    <= op_i;
            r_x     <= w_is_div ? w_b_mag : a_i;
            r_y     <= w_is_div ? w_a_mag : b_i;
            r_z     <= '0;
            r_cnt   <= '0;
            r_dest  <= dest_index_i;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= w_is_div && (b_i == '0);
            r_ill   <= (op_i > c_OP_UMOD);
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op == c_OP_MUL) begin
                r_z <= w_mul_sum;
                r_x <= {r_x[WIDTH-2:0], 1'b0};
                r_y <= {1'b0, r_y[WIDTH-1:1]};
            end else begin
                r_z <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                r_y <= {r_y[WIDTH-2:0], w_ge};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_dest_out <= '0;
            r_dbz_out  <= 1'b0;
            r_ill_out  <= 1'b0;
        end else if (r_state == S_DONE && !flush_i) begin
            r_valid    <= 1'b1;
            r_result   <= w_final;
            r_dest_out <= r_dest;
            r_dbz_out  <= r_dz;
            r_ill_out  <= r_ill;
        end else begin
            r_valid    <= 1'b0;
            r_dbz_out  <= 1'b0;
            r_ill_out  <= 1'b0;
        end
    end

    assign busy_o        = r_busy;
    assign valid_o       = r_valid;
    assign result_o      = r_result;
    assign dest_index_o  = r_dest_out;
    assign div_by_zero_o = r_dbz_out;
    assign illegal_op_o  = r_ill_out;

endmodule
`default_nettype wire
